lvds_sel_ctrl: RTL and testbench
================================

// Module: lvds_sel_ctrl
// PURPOSE
//  Frame-synchronous controller for the 2:1 LVDS video output selector. Drives sel_dest.
//  A requested source change is deferred to the target's next vsync, so the output never carries a torn frame.
//  Monitors vsync activity of both sources and reports liveness.
//  Sits between the AXI-lite control register (sel_req_i) and the output selector, in the pix_clk_i domain.
// PARAMETERS
//  VS_POL          1          vsync active level (1 = active-high, 0 = active-low)
//  DEFAULT_SRC     0          sel_dest value after reset
//  CNT_W           24         width of timeout/liveness counters
//  TIMEOUT_CYCLES  5000000    cycles without a target/source vsync edge before abort / dead (< 2**CNT_W)
// PORTS
//  pix_clk_i    in   1  pixel clock, all logic on rising edge
//  pix_rst_n_i  in   1  asynchronous active-low reset
//  sel_req_i    in   1  requested source (0: lvds 0, 1: lvds 1), level, pix_clk_i-synchronous
//  i_lvds_vs0   in   1  vsync of source 0
//  i_lvds_vs1   in   1  vsync of source 1
//  sel_dest     out  1  registered selector drive to the output mux
//  sel_busy_o   out  1  1 while a switch is armed (state ARM)
//  sw_done_o    out  1  1-cycle pulse, same cycle sel_dest first shows the new value
//  sw_tmo_o     out  1  1-cycle pulse when an armed switch aborts on timeout
//  src_alive_o  out  2  bit n = 1 while source n produced a vsync edge within TIMEOUT_CYCLES
//  failover_o   out  1  1-cycle pulse on automatic failover (0 when LVDS_SEL_FAILOVER_EN undefined)
// BEHAVIOUR
//  Reset:
//   - sel_dest = DEFAULT_SRC; state IDLE
//   - sel_busy_o, sw_done_o, sw_tmo_o, failover_o = 0
//   - liveness counters = 0, so src_alive_o = 2'b11; vs history regs = inactive level
//  Vsync edge: vs_edge[n] = (i_lvds_vsn == VS_POL) && (vs_q[n] != VS_POL); vs_q[n] <= i_lvds_vsn each cycle.
//  Liveness: cnt[n] clears to 0 on vs_edge[n], else increments, saturating at TIMEOUT_CYCLES.
//   src_alive_o[n] = (cnt[n] < TIMEOUT_CYCLES), registered.
//  FSM states:
//   - IDLE: enter ARM when sel_req_i != sel_dest; clear tmo_cnt.
//   - ARM (sel_busy_o=1), per cycle, first matching rule wins:
//     1. sel_req_i == sel_dest -> IDLE, no pulses (cancel beats a same-cycle edge)
//     2. vs_edge[sel_req_i] -> sel_dest <= sel_req_i, sw_done_o=1 next cycle, -> IDLE
//     3. tmo_cnt == TIMEOUT_CYCLES-1 -> sw_tmo_o=1, -> IDLE (re-arms next cycle if request persists)
//     4. else tmo_cnt++
//  Latency: first active vsync cycle of the target at clock edge N -> sel_dest updated after edge N.
//   The downstream register stage therefore emits the full new frame from its first vsync cycle.
//  sel_req_i toggling while in ARM: the target follows sel_req_i live; edge detection uses the current target.
//  sel_dest changes only via ARM rule 2 or failover. Never mid-frame of the target.
//  Reset mid-switch: immediate return to reset values; a pending request re-arms one cycle after release.
// CONFIGURATION
//  LVDS_SEL_FAILOVER_EN defined:
//   - IDLE arms only if src_alive_o[sel_req_i] = 1.
//   - In IDLE, if src_alive_o[sel_dest] = 0 and src_alive_o[~sel_dest] = 1: sel_dest <= ~sel_dest
//     immediately (no vsync wait), failover_o = 1.
//   - When the requested source revives, the normal vsync-aligned switch back occurs.
//  LVDS_SEL_FAILOVER_EN undefined: none of the above; failover_o tied 0; ARM entry unconditional.
// TESTING  (bench: TIMEOUT_CYCLES=1000, vsync period 400 cycles, vs high 5 cycles, VS_POL=1)
//  1. Reset, sel_req_i=0 -> sel_dest=0, src_alive_o=2'b11, all pulses 0.
//  2. sel_req_i 0->1 at cycle 100, vs1 rises at cycle 350 -> sel_busy_o 101..350,
//     sel_dest=1 and sw_done_o=1 at cycle 351 only.
//  3. Armed to 1, sel_req_i back to 0 before any vs1 edge -> IDLE, sel_dest stays 0,
//     no sw_done_o / sw_tmo_o.
//  4. vs1 held low, sel_req_i=1 -> sw_tmo_o pulses every 1001 cycles, sel_dest stays 0,
//     src_alive_o[1]=0 after 1000 cycles.
//  5. Cancel and vs1 edge in the same cycle -> no switch. Timeout and vs1 edge in the same cycle -> switch, no sw_tmo_o.
//  6. FAILOVER_EN: sel_dest=0, stop vs0 -> after 1000 cycles failover_o pulse, sel_dest=1.
//     Restart vs0 -> switch back to 0 on a vs0 edge. Without macro: sel_dest stays 0.

Source files
------------

// File: rtl/lvds_sel_ctrl.sv
// ---------------------------------------------------------------------------
// lvds_sel_ctrl
//
// Frame-synchronous controller for the 2:1 LVDS video output selector.
// A requested source change is held off until the target source's next
// vsync edge, so the output mux never switches in the middle of a frame.
// Both sources are also watched for vsync activity and reported as alive
// or dead.
//
// Optional feature macro: LVDS_SEL_FAILOVER_EN
//   defined   : automatic failover to the other source when the current one
//               goes dead; arming only toward a live source.
//   undefined : no failover, failover_o tied low, arming unconditional.
//
// Ports (all logic on the rising edge of pix_clk_i):
//   pix_clk_i    in   pixel clock
//   pix_rst_n_i  in   asynchronous active-low reset
//   sel_req_i    in   requested source (level, pix_clk_i-synchronous)
//   i_lvds_vs0   in   vsync of source 0
//   i_lvds_vs1   in   vsync of source 1
//   sel_dest     out  registered selector drive to the output mux
//   sel_busy_o   out  1 while a switch is armed
//   sw_done_o    out  1-cycle pulse, same cycle sel_dest shows the new value
//   sw_tmo_o     out  1-cycle pulse when an armed switch times out
//   src_alive_o  out  bit n = 1 while source n had a vsync edge recently
//   failover_o   out  1-cycle pulse on automatic failover
//   dbg_state_o  out  current FSM state (0 = IDLE, 1 = ARM)
//
// Request protocol: sel_req_i is a level, not a valid/ready handshake. The
// controller works toward whatever value sel_req_i holds right now; a
// request is complete when sel_dest equals sel_req_i (sw_done_o marks the
// cycle this happens through a vsync-aligned switch).
// ---------------------------------------------------------------------------
module lvds_sel_ctrl #(
  parameter bit VS_POL         = 1'b1,
  parameter bit DEFAULT_SRC    = 1'b0,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic       pix_clk_i,
  input  logic       pix_rst_n_i,
  input  logic       sel_req_i,
  input  logic       i_lvds_vs0,
  input  logic       i_lvds_vs1,
  output logic       sel_dest,
  output logic       sel_busy_o,
  output logic       sw_done_o,
  output logic       sw_tmo_o,
  output logic [1:0] src_alive_o,
  output logic       failover_o,
  output logic       dbg_state_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ARM  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic                    sel_dest_q, sel_dest_d;
  logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                    done_q, done_d;
  logic                    tmo_q, tmo_d;
  logic [1:0]              vs_q;
  logic [1:0]              vs_in;
  logic [1:0]              vs_edge;
  logic [1:0][CNT_W-1:0]   live_cnt_q, live_cnt_d;
  logic [1:0]              alive_q, alive_d;
`ifdef LVDS_SEL_FAILOVER_EN
  logic                    failover_q, failover_d;
`endif

  assign vs_in = {i_lvds_vs1, i_lvds_vs0};

  // Rising into the active level; history resets to the inactive level so a
  // source already in vsync at reset release still counts as an edge.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      vs_edge[n] = (vs_in[n] == VS_POL) && (vs_q[n] != VS_POL);
    end
  end

  // Liveness counters saturate at the timeout; alive is registered from the
  // next-state count so it always agrees with the current count.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      if (vs_edge[n]) begin
        live_cnt_d[n] = '0;
      end else if (live_cnt_q[n] == TMO_MAX) begin
        live_cnt_d[n] = live_cnt_q[n];
      end else begin
        live_cnt_d[n] = live_cnt_q[n] + CNT_W'(1);
      end
      alive_d[n] = (live_cnt_d[n] < TMO_MAX);
    end
  end

  // Switch FSM. In ARM the target is sel_req_i itself, so a request that
  // changes while armed is followed live.
  always_comb begin
    state_d    = state_q;
    sel_dest_d = sel_dest_q;
    tmo_cnt_d  = tmo_cnt_q;
    done_d     = 1'b0;
    tmo_d      = 1'b0;
`ifdef LVDS_SEL_FAILOVER_EN
    failover_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
`ifdef LVDS_SEL_FAILOVER_EN
        // A dead current source with a live alternative is abandoned at once;
        // there is no frame worth protecting on a dead source.
        if (!alive_q[sel_dest_q] && alive_q[~sel_dest_q]) begin
          sel_dest_d = ~sel_dest_q;
          failover_d = 1'b1;
        end else if ((sel_req_i != sel_dest_q) && alive_q[sel_req_i]) begin
          state_d = ST_ARM;
        end
`else
        if (sel_req_i != sel_dest_q) begin
          state_d = ST_ARM;
        end
`endif
      end
      ST_ARM: begin
        // Priority: cancel, then vsync edge, then timeout.
        if (sel_req_i == sel_dest_q) begin
          state_d = ST_IDLE;
        end else if (vs_edge[sel_req_i]) begin
          sel_dest_d = sel_req_i;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pix_clk_i or negedge pix_rst_n_i) begin
    if (!pix_rst_n_i) begin
      state_q    <= ST_IDLE;
      sel_dest_q <= DEFAULT_SRC;
      tmo_cnt_q  <= '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      vs_q       <= {2{~VS_POL}};
      live_cnt_q <= '0;
      alive_q    <= 2'b11;
`ifdef LVDS_SEL_FAILOVER_EN
      failover_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_dest_q <= sel_dest_d;
      tmo_cnt_q  <= tmo_cnt_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      vs_q       <= vs_in;
      live_cnt_q <= live_cnt_d;
      alive_q    <= alive_d;
`ifdef LVDS_SEL_FAILOVER_EN
      failover_q <= failover_d;
`endif
    end
  end

  assign sel_dest    = sel_dest_q;
  assign sel_busy_o  = (state_q == ST_ARM);
  assign sw_done_o   = done_q;
  assign sw_tmo_o    = tmo_q;
  assign src_alive_o = alive_q;
  assign dbg_state_o = state_q;
`ifdef LVDS_SEL_FAILOVER_EN
  assign failover_o  = failover_q;
`else
  assign failover_o  = 1'b0;
`endif

endmodule

// File: tb/tb_lvds_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lvds_sel_ctrl
//
// Bench for lvds_sel_ctrl with TIMEOUT_CYCLES=1000, VS_POL=1, vsync pulses
// 5 cycles high. Inputs change 1 time unit after a rising edge; a value set
// while cyc == k is seen by the DUT at edge k+1, and its registered outputs
// are sampled with cyc == k+1. Pulse events (done/timeout/failover) are
// predicted when the stimulus is driven, queued with their expected cycle
// and resulting sel_dest, and matched by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_lvds_sel_ctrl;

  localparam int T = 1000;
  localparam logic [2:0] EV_DONE = 3'b001;
  localparam logic [2:0] EV_TMO  = 3'b010;
  localparam logic [2:0] EV_FO   = 3'b100;
`ifdef LVDS_SEL_FAILOVER_EN
  localparam bit FO_EN = 1'b1;
`else
  localparam bit FO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       sel_req;
  logic [1:0] vs;
  logic       sel_dest;
  logic       sel_busy;
  logic       sw_done;
  logic       sw_tmo;
  logic [1:0] src_alive;
  logic       failover;
  logic       dbg_state;

  int          cyc;
  int          n_checks;
  int          n_fail;
  int          last_edge [2];
  int          hold [2];
  logic [31:0] exp_q [$];

  lvds_sel_ctrl #(
    .VS_POL        (1'b1),
    .DEFAULT_SRC   (1'b0),
    .CNT_W         (24),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .pix_clk_i   (clk),
    .pix_rst_n_i (rst_n),
    .sel_req_i   (sel_req),
    .i_lvds_vs0  (vs[0]),
    .i_lvds_vs1  (vs[1]),
    .sel_dest    (sel_dest),
    .sel_busy_o  (sel_busy),
    .sw_done_o   (sw_done),
    .sw_tmo_o    (sw_tmo),
    .src_alive_o (src_alive),
    .failover_o  (failover),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < 2; n++) begin
      if (hold[n] > 0) begin
        hold[n]--;
        if (hold[n] == 0) vs[n] = 1'b0;
      end
    end
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  task automatic vs_pulse(input int n);
    vs[n]        = 1'b1;
    hold[n]      = 5;
    last_edge[n] = cyc + 1;
  endtask

  task automatic push_evt(input logic [2:0] kind, input logic dest, input int at);
    logic [27:0] at_w;
    at_w = at[27:0];
    exp_q.push_back({kind, dest, at_w});
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    logic [31:0] obs;
    logic [27:0] cyc_w;
    if (rst_n && (sw_done || sw_tmo || failover)) begin
      cyc_w = cyc[27:0];
      obs   = {failover, sw_tmo, sw_done, sel_dest, cyc_w};
      if (exp_q.size() == 0) check_eq("unexpected_evt", obs, 32'h0);
      else                   check_eq("evt", obs, exp_q.pop_front());
    end
  end

  initial begin
    int s;
    int last0;
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    sel_req      = 1'b0;
    vs           = 2'b00;
    hold[0]      = 0;
    hold[1]      = 0;
    last_edge[0] = 0;
    last_edge[1] = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dest", {31'd0, sel_dest}, 32'd0);
    check_eq("rst_alive", {30'd0, src_alive}, 32'd3);
    check_eq("rst_busy", {31'd0, sel_busy}, 32'd0);
    check_eq("rst_pulses", {29'd0, failover, sw_tmo, sw_done}, 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
    ticks(5);
    vs_pulse(0);
    vs_pulse(1);
    ticks(10);

    // Arm toward 1, cancel before any vs1 edge
    sel_req = 1'b1;
    tick();
    check_eq("arm_busy", {31'd0, sel_busy}, 32'd1);
    ticks(49);
    sel_req = 1'b0;
    tick();
    check_eq("cancel_idle", {30'd0, sel_busy, sel_dest}, 32'd0);
    vs_pulse(1);
    ticks(10);
    check_eq("cancel_dest", {31'd0, sel_dest}, 32'd0);

    // Normal switch 0 -> 1 after 250 armed cycles
    sel_req = 1'b1;
    for (int i = 0; i < 250; i++) begin
      tick();
      check_eq("sw_wait", {30'd0, sel_busy, sel_dest}, 32'd2);
    end
    vs_pulse(1);
    push_evt(EV_DONE, 1'b1, cyc + 1);
    tick();
    check_eq("sw_dest", {30'd0, sel_busy, sel_dest}, 32'd1);
    ticks(10);

    // Cancel and target vsync edge in the same cycle: cancel wins
    sel_req = 1'b0;
    ticks(20);
    check_eq("arm_busy2", {31'd0, sel_busy}, 32'd1);
    sel_req = 1'b1;
    vs_pulse(0);
    tick();
    check_eq("cancel_edge", {30'd0, sel_busy, sel_dest}, 32'd1);
    ticks(10);
    check_eq("cancel_edge_hold", {31'd0, sel_dest}, 32'd1);

    // Timeout and target vsync edge in the same cycle: switch, no timeout
    sel_req = 1'b0;
    ticks(T);
    vs_pulse(0);
    push_evt(EV_DONE, 1'b0, cyc + 1);
    tick();
    check_eq("tmo_edge", {30'd0, sel_busy, sel_dest}, 32'd0);
    ticks(10);

    // vs1 stays low: repeated timeouts every T+1 cycles, liveness drops
    vs_pulse(1);
    ticks(10);
    vs_pulse(0);
    ticks(10);
    sel_req = 1'b1;
    s = cyc;
    push_evt(EV_TMO, 1'b0, s + T + 1);
    push_evt(EV_TMO, 1'b0, s + 2 * T + 2);
    while (cyc < s + 2 * T + 5) begin
      tick();
      if (cyc == last_edge[1] + T - 1) check_eq("alive1_hold", {31'd0, src_alive[1]}, 32'd1);
      if (cyc == last_edge[1] + T)     check_eq("alive1_drop", {31'd0, src_alive[1]}, 32'd0);
    end
    check_eq("tmo_rearmed", {30'd0, sel_busy, sel_dest}, 32'd2);
    sel_req = 1'b0;
    tick();
    check_eq("tmo_cancel", {30'd0, sel_busy, sel_dest}, 32'd0);

    // Source 0 goes dead while selected, source 1 keeps running
    vs_pulse(1);
    ticks(10);
    vs_pulse(0);
    last0 = last_edge[0];
    if (FO_EN) push_evt(EV_FO, 1'b1, last0 + T + 1);
    while (cyc < last0 + T + 100) begin
      tick();
      if (hold[1] == 0 && (cyc - last_edge[1]) >= 400) vs_pulse(1);
      if (cyc == last0 + T - 1) check_eq("alive0_hold", {31'd0, src_alive[0]}, 32'd1);
      if (cyc == last0 + T)     check_eq("alive0_drop", {30'd0, src_alive}, 32'd2);
    end
    check_eq("fo_dest", {31'd0, sel_dest}, {31'd0, FO_EN});
    if (FO_EN) begin
      // Source 0 revives: vsync-aligned switch back
      vs_pulse(0);
      ticks(10);
      vs_pulse(0);
      push_evt(EV_DONE, 1'b0, cyc + 1);
      tick();
      check_eq("fo_back", {31'd0, sel_dest}, 32'd0);
    end
    ticks(10);

    // Reset in the middle of an armed switch
    vs_pulse(0);
    vs_pulse(1);
    ticks(10);
    sel_req = 1'b1;
    ticks(10);
    check_eq("mid_armed", {31'd0, sel_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst", {25'd0, sel_busy, failover, sw_tmo, sw_done, sel_dest, src_alive}, 32'd3);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rearm_after_rst", {30'd0, sel_busy, sel_dest}, 32'd2);
    sel_req = 1'b0;
    tick();
    check_eq("final_idle", {31'd0, sel_busy}, 32'd0);
    ticks(5);

    check_eq("sb_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
